// File: rtl/ram_bridge_16b_if.sv
// ---------------------------------------------------------------------------
// ram_bridge_16b_if
// Core-side data-memory handshake of the 16-bit RAM bridge.
//   req_i   : request, sampled by the bridge only while idle
//   we_i    : byte-lane write strobes (4'b0000 = read)
//   addr_i  : byte address
//   data_i  : store data, lane k = data_i[8k+7:8k]
//   data_o  : read data, held until the next read completes
//   busy_o  : bridge is working on a transaction
//   done_o  : one-cycle completion pulse
// modport master : the core (drives the request)
// modport slave  : the bridge (answers the request)
// ---------------------------------------------------------------------------
interface ram_bridge_16b_if;
   logic        req_i;
   logic [3:0]  we_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        busy_o;
   logic        done_o;

   modport master (
      output req_i, we_i, addr_i, data_i,
      input  data_o, busy_o, done_o
   );

   modport slave (
      input  req_i, we_i, addr_i, data_i,
      output data_o, busy_o, done_o
   );
endinterface

// File: rtl/ram_bridge_16b.sv
// ---------------------------------------------------------------------------
// ram_bridge_16b
// Bridges a 32-bit byte-addressed core data port onto a 16-bit-word RAM that
// returns halfwords H and H+1 on each read and writes one whole halfword per
// cycle (no byte enables). Reads become one RAM read; stores become one or
// two halfword writes, with a single read-modify-write read shared by both
// halves whenever a halfword is only partially written.
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-low reset
//   core          : core handshake (ram_bridge_16b_if.slave)
//   mem_en_o      : RAM enable
//   mem_we_o      : RAM write enable
//   mem_addr_o    : RAM halfword address
//   mem_data_o    : RAM write data, [31:16] always zero
//   mem_data_a_i  : RAM halfword H   (low 16 bits used)
//   mem_data_b_i  : RAM halfword H+1 (low 16 bits used)
// All outputs are registered: the RAM controls for a state are loaded on the
// edge that enters that state.
// ---------------------------------------------------------------------------
module ram_bridge_16b #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   ram_bridge_16b_if.slave   core,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_data_o,
   input  logic [31:0]       mem_data_a_i,
   input  logic [31:0]       mem_data_b_i
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RD_ISSUE  = 3'd1,
      RD_WAIT   = 3'd2,
      RMW_ISSUE = 3'd3,
      RMW_WAIT  = 3'd4,
      WR_LO     = 3'd5,
      WR_HI     = 3'd6,
      RESP      = 3'd7
   } state_t;

   state_t            state;
   logic [ADDR_W:0]   addr_q;     // byte address bits that matter
   logic [3:0]        we_q;
   logic [31:0]       data_q;
   logic [15:0]       old0;
   logic [15:0]       old1;
   logic [31:0]       rd_data;
   logic              busy;
   logic              done;

   // Byte-wise merge: strobe set takes the new byte, clear keeps the old one.
   function automatic logic [15:0] merge16(input logic [15:0] new_hw,
                                           input logic [15:0] old_hw,
                                           input logic [1:0]  strb);
      merge16 = {(strb[1] ? new_hw[15:8] : old_hw[15:8]),
                 (strb[0] ? new_hw[7:0]  : old_hw[7:0])};
   endfunction

   // A halfword with exactly one strobe set needs its other byte read back.
   function automatic logic has_partial(input logic [3:0] we);
      has_partial = (we[1] ^ we[0]) | (we[3] ^ we[2]);
   endfunction

   // Halfword addresses of the write pair; H0 is even so H1 never wraps.
   function automatic logic [ADDR_W-1:0] hw0(input logic [ADDR_W:0] a);
      hw0 = {a[ADDR_W:2], 1'b0};
   endfunction

   function automatic logic [ADDR_W-1:0] hw1(input logic [ADDR_W:0] a);
      hw1 = {a[ADDR_W:2], 1'b1};
   endfunction

   assign core.data_o = rd_data;
   assign core.busy_o = busy;
   assign core.done_o = done;

   // Bits the bridge deliberately ignores.
   logic unused_bits;
   assign unused_bits = ^{core.addr_i[31:ADDR_W+1],
                          mem_data_a_i[31:16], mem_data_b_i[31:16]};

   // Transaction sequencer with registered core and RAM outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         addr_q     <= {(ADDR_W+1){1'b0}};
         we_q       <= 4'b0000;
         data_q     <= 32'h0000_0000;
         old0       <= 16'h0000;
         old1       <= 16'h0000;
         rd_data    <= 32'h0000_0000;
         busy       <= 1'b0;
         done       <= 1'b0;
         mem_en_o   <= 1'b0;
         mem_we_o   <= 1'b0;
         mem_addr_o <= {ADDR_W{1'b0}};
         mem_data_o <= 32'h0000_0000;
      end else begin
         case (state)
            IDLE: begin
               if (core.req_i) begin
                  addr_q <= core.addr_i[ADDR_W:0];
                  we_q   <= core.we_i;
                  data_q <= core.data_i;
                  busy   <= 1'b1;
                  if (core.we_i == 4'b0000) begin
                     state      <= RD_ISSUE;
                     mem_en_o   <= 1'b1;
                     mem_we_o   <= 1'b0;
                     mem_addr_o <= core.addr_i[ADDR_W:1];
                  end else if (has_partial(core.we_i)) begin
                     state      <= RMW_ISSUE;
                     mem_en_o   <= 1'b1;
                     mem_we_o   <= 1'b0;
                     mem_addr_o <= hw0(core.addr_i[ADDR_W:0]);
                  end else if (core.we_i[1:0] == 2'b11) begin
                     // Full low halfword: no old data needed.
                     state      <= WR_LO;
                     mem_en_o   <= 1'b1;
                     mem_we_o   <= 1'b1;
                     mem_addr_o <= hw0(core.addr_i[ADDR_W:0]);
                     mem_data_o <= {16'h0000, core.data_i[15:0]};
                  end else begin
                     state      <= WR_HI;
                     mem_en_o   <= 1'b1;
                     mem_we_o   <= 1'b1;
                     mem_addr_o <= hw1(core.addr_i[ADDR_W:0]);
                     mem_data_o <= {16'h0000, core.data_i[31:16]};
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RD_ISSUE: begin
               state    <= RD_WAIT;
               mem_en_o <= 1'b0;
            end
            RD_WAIT: begin
               // Odd byte address shifts right one byte, zero-filling the top.
               if (addr_q[0]) begin
                  rd_data <= {8'h00, mem_data_b_i[15:0], mem_data_a_i[15:8]};
               end else begin
                  rd_data <= {mem_data_b_i[15:0], mem_data_a_i[15:0]};
               end
               state <= RESP;
               done  <= 1'b1;
            end
            RMW_ISSUE: begin
               state    <= RMW_WAIT;
               mem_en_o <= 1'b0;
            end
            RMW_WAIT: begin
               // One read at H0 returns both old halfwords.
               old0     <= mem_data_a_i[15:0];
               old1     <= mem_data_b_i[15:0];
               mem_en_o <= 1'b1;
               mem_we_o <= 1'b1;
               if (we_q[1:0] != 2'b00) begin
                  state      <= WR_LO;
                  mem_addr_o <= hw0(addr_q);
                  mem_data_o <= {16'h0000, merge16(data_q[15:0], mem_data_a_i[15:0], we_q[1:0])};
               end else begin
                  state      <= WR_HI;
                  mem_addr_o <= hw1(addr_q);
                  mem_data_o <= {16'h0000, merge16(data_q[31:16], mem_data_b_i[15:0], we_q[3:2])};
               end
            end
            WR_LO: begin
               if (we_q[3:2] != 2'b00) begin
                  // old1 is only stale on the non-RMW path, where both strobes are set.
                  state      <= WR_HI;
                  mem_addr_o <= hw1(addr_q);
                  mem_data_o <= {16'h0000, merge16(data_q[31:16], old1, we_q[3:2])};
               end else begin
                  state    <= RESP;
                  mem_en_o <= 1'b0;
                  mem_we_o <= 1'b0;
                  done     <= 1'b1;
               end
            end
            WR_HI: begin
               state    <= RESP;
               mem_en_o <= 1'b0;
               mem_we_o <= 1'b0;
               done     <= 1'b1;
            end
            RESP: begin
               // A request present here is not taken; it must reappear in IDLE.
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               done     <= 1'b0;
               mem_en_o <= 1'b0;
               mem_we_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_bridge_16b.sv
// ---------------------------------------------------------------------------
// tb_ram_bridge_16b
// Drives ram_bridge_16b against a behavioural 16-bit RAM and compares every
// transaction cycle with a transaction-level model (RAM image array, expected
// latency, expected RAM read/write counts, expected data_o).
// ---------------------------------------------------------------------------
module tb_ram_bridge_16b;

   logic        clk;
   logic        rst;
   logic        mem_en_o;
   logic        mem_we_o;
   logic [15:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic [31:0] mem_data_a_i;
   logic [31:0] mem_data_b_i;

   ram_bridge_16b_if bus ();

   ram_bridge_16b #(.ADDR_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .core         (bus),
      .mem_en_o     (mem_en_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .mem_data_a_i (mem_data_a_i),
      .mem_data_b_i (mem_data_b_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural RAM ----------------
   logic [15:0] ram [0:65535];
   logic [15:0] ra, rb;
   int          rd_cnt, wr_cnt, hi_bad;
   logic        poke;
   logic [15:0] poke_addr, poke_data;

   assign mem_data_a_i = {16'h0000, ra};
   assign mem_data_b_i = {16'h0000, rb};

   always @(posedge clk) begin
      if (poke) ram[poke_addr] <= poke_data;
      if (mem_en_o) begin
         ra <= ram[mem_addr_o];
         rb <= ram[mem_addr_o + 16'd1];
         if (mem_we_o) begin
            ram[mem_addr_o] <= mem_data_o[15:0];
            wr_cnt <= wr_cnt + 1;
            if (mem_data_o[31:16] != 16'h0000) hi_bad <= hi_bad + 1;
         end else begin
            rd_cnt <= rd_cnt + 1;
         end
      end
   end

   // ---------------- model state / bookkeeping ----------------
   logic [15:0] mdl [0:65535];
   logic [31:0] prev_data;
   int          total, bad;
   int          obs_rd, obs_wr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Transaction-level model: what the RAM and data_o must look like afterwards.
   task automatic model_exec(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data,
                             output int lat, output int nrd, output int nwr, output logic [31:0] dout);
      logic [15:0] hr, hn, h0;
      logic [31:0] w;
      logic [1:0]  s;
      logic [15:0] v;
      bit          part;
      if (we == 4'b0000) begin
         hr   = addr[16:1];
         hn   = hr + 16'd1;
         w    = {mdl[hn], mdl[hr]};
         dout = addr[0] ? (w >> 8) : w;
         lat  = 3; nrd = 1; nwr = 0;
      end else begin
         h0 = {addr[16:2], 1'b0};
         part = 1'b0; nwr = 0;
         for (int h = 0; h < 2; h++) begin
            s = we[2*h +: 2];
            if (s == 2'b01 || s == 2'b10) part = 1'b1;
            if (s != 2'b00) begin
               nwr++;
               v = mdl[h0 + h[15:0]];
               for (int b = 0; b < 2; b++)
                  if (s[b]) v[8*b +: 8] = data[16*h + 8*b +: 8];
               mdl[h0 + h[15:0]] = v;
            end
         end
         nrd  = part ? 1 : 0;
         lat  = part ? 3 + nwr : 1 + nwr;
         dout = prev_data;
      end
   endtask

   task automatic do_poke(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      poke = 1'b1; poke_addr = a; poke_data = d;
      mdl[a] = d;
      @(posedge clk); #1;
      poke = 1'b0;
   endtask

   task automatic check_image(input string nm);
      int n;
      n = 0;
      for (int i = 0; i < 66; i++) if (ram[i] !== mdl[i]) n++;
      if (ram[16'hFFFF] !== mdl[16'hFFFF]) n++;
      chk(nm, n, 0);
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_busy", bus.busy_o, 1'b0);
         chk("idle_mem_en", mem_en_o, 1'b0);
      end
   endtask

   // One transaction, checked on every cycle until the bridge is idle again.
   task automatic do_txn(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data,
                         input bit hold, output int obs_lat);
      int          elat, erd, ewr, rd0, wr0;
      logic [31:0] edat, pd;
      pd = prev_data;
      model_exec(we, addr, data, elat, erd, ewr, edat);
      @(negedge clk);
      bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.data_i = data;
      @(posedge clk); #1;
      rd0 = rd_cnt; wr0 = wr_cnt;
      if (!hold) begin
         bus.req_i  = 1'b0;
         bus.we_i   = 4'($urandom);
         bus.addr_i = $urandom;
         bus.data_i = $urandom;
      end
      obs_lat = 0;
      for (int c = 1; c <= elat; c++) begin
         @(negedge clk);
         if (bus.done_o && obs_lat == 0) obs_lat = c;
         chk("busy", bus.busy_o, 1'b1);
         chk("done", bus.done_o, (c == elat));
         chk("data_o", bus.data_o, (c == elat) ? edat : pd);
      end
      @(negedge clk);
      if (hold) begin
         chk("hold_busy_a", bus.busy_o, 1'b0);
         bus.req_i = 1'b0;
         @(negedge clk);
      end
      chk("end_busy", bus.busy_o, 1'b0);
      chk("end_done", bus.done_o, 1'b0);
      obs_rd = rd_cnt - rd0;
      obs_wr = wr_cnt - wr0;
      chk("ram_reads", obs_rd, erd);
      chk("ram_writes", obs_wr, ewr);
      check_image("ram_image");
      prev_data = edat;
   endtask

   int          lat;
   logic [3:0]  rwe;
   logic [31:0] raddr, rdat;
   logic [15:0] h0r;

   initial begin
      total = 0; bad = 0; rd_cnt = 0; wr_cnt = 0; hi_bad = 0;
      poke = 1'b0; poke_addr = 16'h0000; poke_data = 16'h0000;
      prev_data = 32'h0000_0000;
      bus.req_i = 1'b0; bus.we_i = 4'b0000; bus.addr_i = 32'h0; bus.data_i = 32'h0;
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("rst_busy", bus.busy_o, 1'b0);
      chk("rst_done", bus.done_o, 1'b0);
      chk("rst_mem_en", mem_en_o, 1'b0);
      chk("rst_mem_we", mem_we_o, 1'b0);
      chk("rst_mem_addr", mem_addr_o, 16'h0000);
      chk("rst_mem_data", mem_data_o, 32'h0);
      chk("rst_data_o", bus.data_o, 32'h0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 66; i++) do_poke(i[15:0], 16'($urandom));
      do_poke(16'hFFFF, 16'($urandom));

      // Word write then aligned read.
      do_txn(4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, lat);
      chk("t1_lat", lat, 3);
      chk("t1_reads", obs_rd, 0);
      chk("t1_ram8", ram[8], 16'hBEEF);
      chk("t1_ram9", ram[9], 16'hDEAD);
      do_txn(4'b0000, 32'h0000_0010, 32'h0, 1'b0, lat);
      chk("t1r_lat", lat, 3);
      chk("t1r_data", bus.data_o, 32'hDEAD_BEEF);

      // Odd read.
      do_txn(4'b0000, 32'h0000_0011, 32'h0, 1'b0, lat);
      chk("odd_data", bus.data_o, 32'h00DE_ADBE);

      // One partial halfword.
      do_txn(4'b0010, 32'h0000_0010, 32'h0000_5500, 1'b0, lat);
      chk("t2_lat", lat, 4);
      chk("t2_reads", obs_rd, 1);
      chk("t2_writes", obs_wr, 1);
      chk("t2_ram8", ram[8], 16'h55EF);
      chk("t2_ram9", ram[9], 16'hDEAD);

      // Partial + full halfword, restore RAM[8] first.
      do_poke(16'd8, 16'hBEEF);
      do_txn(4'b0111, 32'h0000_0010, 32'h0011_2233, 1'b0, lat);
      chk("t3_lat", lat, 5);
      chk("t3_reads", obs_rd, 1);
      chk("t3_ram8", ram[8], 16'h2233);
      chk("t3_ram9", ram[9], 16'hDE11);

      // Wrapping read.
      do_poke(16'hFFFF, 16'h1234);
      do_poke(16'h0000, 16'h5678);
      do_txn(4'b0000, 32'h0001_FFFE, 32'h0, 1'b0, lat);
      chk("wrap_data", bus.data_o, 32'h5678_1234);

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         rwe   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
         raddr = {15'($urandom), 10'h000, 7'($urandom)};
         rdat  = $urandom;
         do_txn(rwe, raddr, rdat, ($urandom_range(0, 7) == 0), lat);
         idle_gap($urandom_range(0, 2));
      end
      chk("hi_half_zero", hi_bad, 0);

      // Reset during WR_HI of a word write.
      raddr = {25'h0, 5'($urandom), 2'b00};
      rdat  = $urandom;
      h0r   = {raddr[16:2], 1'b0};
      @(negedge clk);
      bus.req_i = 1'b1; bus.we_i = 4'b1111; bus.addr_i = raddr; bus.data_i = rdat;
      @(posedge clk); #1;
      bus.req_i = 1'b0;
      @(negedge clk);           // WR_LO cycle
      @(negedge clk);           // WR_HI cycle
      rst = 1'b0;
      #1;
      chk("mid_busy", bus.busy_o, 1'b0);
      chk("mid_done", bus.done_o, 1'b0);
      chk("mid_mem_en", mem_en_o, 1'b0);
      chk("mid_mem_we", mem_we_o, 1'b0);
      chk("mid_mem_addr", mem_addr_o, 16'h0000);
      chk("mid_mem_data", mem_data_o, 32'h0);
      chk("mid_data_o", bus.data_o, 32'h0);
      mdl[h0r] = rdat[15:0];
      prev_data = 32'h0;
      @(negedge clk);
      rst = 1'b1;
      check_image("mid_image");
      do_txn(4'b0000, raddr, 32'h0, 1'b1, lat);
      chk("post_rst_lat", lat, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_bridge_16b.md
# ram_bridge_16b

Bridges the core's 32-bit byte-addressed data-memory port to the 16-bit-word simulation RAM (RAM_mem_16b). That RAM returns halfwords H and H+1 on every read, writes one full halfword per cycle and has no byte enables. This block acts as the initiator on that RAM port. It turns core reads into single RAM reads and core stores into one or two halfword writes, using read-modify-write for partial halfwords.

## Interface
Parameters:
- ADDR_W, 16, RAM halfword-address width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_i  in  1  request; sampled only in IDLE
- we_i  in  4  byte-lane write strobes of the word at {addr_i[31:2],2'b00}; 4'b0000 = read
- addr_i  in  32  byte address
- data_i  in  32  store data, lane k = data_i[8k+7:8k]
- data_o  out  32  read data; held until next read completes
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- mem_en_o  out  1  RAM enable
- mem_we_o  out  1  RAM write enable
- mem_addr_o  out  ADDR_W  RAM halfword address
- mem_data_o  out  32  RAM write data; [31:16] always 0
- mem_data_a_i  in  32  RAM halfword H, low 16 bits used
- mem_data_b_i  in  32  RAM halfword H+1, low 16 bits used

## Operation
- Address derivation:
  - Read address Hr = addr_i[16:1].
  - Write base H0 = {addr_i[16:2],1'b0}; H1 = H0+1.
  - addr_i[31:17] is ignored.
- In IDLE, req_i latches addr/we/data into registers and goes to the next state:
  - we_i==0 goes to RD_ISSUE.
  - Any halfword with strobes 01 or 10 ("partial") goes to RMW_ISSUE.
  - Otherwise we_i[1:0]==11 goes to WR_LO.
  - Otherwise goes to WR_HI.
- RD_ISSUE: mem_en=1, we=0, addr=Hr; go to RD_WAIT.
- RD_WAIT:
  - data_o <= {b[15:0],a[15:0]} >> (8*addr_q[0]); the upper byte is zero when odd.
  - Go to RESP.
- RMW_ISSUE: read at H0; go to RMW_WAIT.
- RMW_WAIT:
  - old0 <= a[15:0], old1 <= b[15:0]. A single read serves both halves.
  - Go to WR_LO if we_q[1:0]!=0, else WR_HI.
- WR_LO:
  - mem_en=1, we=1, addr=H0.
  - Data is a per-byte merge of data_q[15:0] (strobe set) and old0 (strobe clear).
  - Go to WR_HI if we_q[3:2]!=0, else RESP.
- WR_HI: write H1 with the merge of data_q[31:16] and old1; go to RESP.
- RESP: done_o=1; go to IDLE. A req_i seen in RESP is ignored and must be re-presented in IDLE.
- A halfword with strobes 00 is never written.
- Writes never alter data_o.
- Reads do not wrap or mask: Hr=0xFFFF returns b from halfword 0x0000, because the RAM's +1 wraps. H1 never wraps since H0 is even.
- Core inputs need not be held after acceptance.

## Timing
- Request accepted at edge T (state IDLE).
- done_o latencies:
  - Read: cycle T+3.
  - Full-halfword-only write: T+2 (one halfword) or T+3 (word).
  - RMW with one partial halfword: T+4.
  - RMW touching both halfwords: T+5.
- RAM read data is used exactly one cycle after the read issue cycle.
- mem_en_o=0 in IDLE, RMW_WAIT, RD_WAIT and RESP.
- Reset (rst low, asynchronous):
  - State returns to IDLE.
  - busy_o, done_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o, data_o and the internal latches all read 0.
- Reset mid-operation drops the transaction. A completed WR_LO write persists and is not rolled back.
- After reset release, the first rising edge with req_i=1 is accepted.

## Test plan
- Word write 0xDEADBEEF at addr 0x10, we=1111 -> RAM[8]=0xBEEF, RAM[9]=0xDEAD, no RAM read, done_o at T+3. Then a read at 0x10 -> data_o=0xDEADBEEF, done_o at T+3.
- RAM[8]=0xBEEF, RAM[9]=0xDEAD; write addr 0x10, we=0010, data 0x00005500 -> one read at 8, RAM[8]=0x55EF, no write to address 9, done_o at T+4.
- Same preload; we=0111, data 0x00112233 -> exactly one RAM read, RAM[8]=0x2233, RAM[9]=0xDE11, done_o at T+5.
- Odd read at addr 0x11 after the first test -> data_o=0x00DEADBE.
- Wrap read: RAM[0xFFFF]=0x1234, RAM[0x0000]=0x5678, read addr 0x0001FFFE -> data_o=0x56781234.
- Reset mid-write: pull rst low during WR_HI of a word write -> all outputs 0 immediately, RAM[H0] updated, RAM[H1] unchanged. A new read after release completes normally; req_i held through RESP yields only one transaction.
